if_prefetch: RTL and testbench

- Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. It replaces the fixed pc_reg plus zero-latency ROM fetch path.
- Drives a ROM/bus interface that has request/grant handshake and in-order, variable-latency responses.
- Buffers fetched {pc, inst} pairs and presents them to the ID stage under a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 27 ++
 rtl/if_prefetch_inst_fifo.sv | 76 +++++++
 rtl/if_prefetch.sv | 172 +++++++++++++++++
 tb/tb_if_prefetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

  // Default bus widths, matching the instruction address and data buses.
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_INST_W      = 32;

  // Default prefetch queue depth (also the live-request credit limit).
  localparam int FETCH_DEPTH     = 4;

  // Byte distance between consecutive instructions.
  localparam int PC_STEP         = 4;

  // Low address bits forced to zero on a redirect (word alignment).
  localparam int INST_ALIGN_MASK = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Width of the outstanding/drop counters: must hold 0 .. 2*depth.
  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_inst_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries for the ID stage.
// Clear has priority over push; a pop on an empty FIFO is ignored and a
// push on a full FIFO is only accepted together with a pop.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an entry is only read after it was written.
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue. Issues in-order
// requests to a ROM/bus with variable response latency, buffers {pc, inst}
// pairs for ID, and flushes on branch redirects while discarding responses
// to requests that were already in flight.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [INST_W-1:0] rom_rdata_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i
);

  localparam int                CNT_W      = cnt_width(DEPTH);
  localparam int                QCNT_W     = $clog2(DEPTH) + 1;
  localparam int                ENTRY_W    = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN      = ~ADDR_W'(INST_ALIGN_MASK);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  OUT_MAX    = CNT_W'(2 * DEPTH);

  fetch_state_e      state_q, state_d;
  logic              run;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  live;
  logic              gnt_seen_q;

  logic              grant;
  logic              resp_accept;
  logic              branch_take;
  logic              q_push;
  logic              q_pop;
  logic [QCNT_W-1:0] q_count;
  logic              q_full;
  logic              q_empty;
  logic [ENTRY_W-1:0] q_head;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one idle cycle after reset, then run until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: fetching is enabled only in RUN and never while reset is held
  always_comb begin
    run = 1'b0;
    case (state_q)
      ST_RUN:  run = !rst;
      default: run = 1'b0;
    endcase
  end

  assign rom_ce_o = run;

  // Credits: queued entries plus responses still expected to land in the queue
  assign live        = out_cnt_q - drop_cnt_q;
  assign rom_req_o   = run && !branch_flag_i
                       && ((CNT_W'(q_count) + live) < CREDIT_MAX)
                       && (out_cnt_q < OUT_MAX);
  assign rom_addr_o  = fetch_pc_q;
  assign grant       = rom_req_o && rom_gnt_i;
  assign resp_accept = rom_rvalid_i && (out_cnt_q != '0);
  assign branch_take = run && branch_flag_i;
  assign q_push      = resp_accept && (drop_cnt_q == '0);
  assign q_pop       = id_valid_o && id_ready_i;

  // Fetch/response PCs and outstanding/drop counters
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (grant) fetch_pc_d = fetch_pc_q + STEP;

    if (grant && !resp_accept)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!grant && resp_accept) out_cnt_d = out_cnt_q - CNT_W'(1);

    if (resp_accept) begin
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      else                  resp_pc_d  = resp_pc_q + STEP;
    end

    // A redirect overrides both PCs; everything still outstanding after this
    // edge's response update belongs to the old path and must be dropped.
    if (branch_take) begin
      fetch_pc_d = branch_target_i & ALIGN;
      resp_pc_d  = branch_target_i & ALIGN;
      drop_cnt_d = out_cnt_d;
    end
  end

  // Fetch/response PCs and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      gnt_seen_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      gnt_seen_q <= gnt_seen_q || grant;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (branch_take),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i ({resp_pc_q, rom_rdata_i}),
    .rdata_o (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Head fields are masked while empty so reset presents all-zero ID outputs
  assign id_valid_o = !q_empty;
  assign id_pc_o    = q_empty ? '0 : q_head[ENTRY_W-1:INST_W];
  assign id_inst_o  = q_empty ? '0 : q_head[INST_W-1:0];

  // Responses to requests abandoned by a reset may still arrive before the
  // first new grant; any response with nothing outstanding after that point
  // is a bus protocol violation.
  assert property (@(posedge clk) disable iff (rst)
    !(rom_rvalid_i && (out_cnt_q == '0) && gnt_seen_q))
    else $error("if_prefetch: response with no outstanding request");

  // The credit rule must keep the queue from ever overflowing.
  assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop && !branch_take))
    else $error("if_prefetch: prefetch queue overflow");

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: directed scenarios push the PCs that ID
// must receive; a monitor pops and compares on every ID transfer.
module tb_if_prefetch;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rom_ce_o;
  logic              rom_req_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_gnt_i;
  logic              rom_rvalid_i;
  logic [INST_W-1:0] rom_rdata_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_ready_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;

  int n_tests   = 0;
  int n_fail    = 0;
  int deliv_cnt = 0;
  int gnt_cnt   = 0;
  int lat       = 1;
  int cyc       = 0;

  logic [ADDR_W-1:0] sb [$];
  logic [ADDR_W-1:0] pend_addr [$];
  int                pend_due [$];

  if_prefetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_req_o       (rom_req_o),
    .rom_addr_o      (rom_addr_o),
    .rom_gnt_i       (rom_gnt_i),
    .rom_rvalid_i    (rom_rvalid_i),
    .rom_rdata_i     (rom_rdata_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_ready_i      (id_ready_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i)
  );

  always #5 clk = ~clk;

  // ROM contents: a fixed scramble of the address.
  function automatic logic [INST_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
    return addr ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-order ROM: a grant in cycle t answers in cycle t+lat.
  initial begin : rom_model
    logic              g;
    logic              consumed;
    logic [ADDR_W-1:0] a;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = '0;
    forever begin
      @(negedge clk);
      g        = rom_req_o && rom_gnt_i;
      a        = rom_addr_o;
      consumed = rom_rvalid_i;
      if (g) gnt_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (consumed && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (g) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc - 1 + lat);
      end
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = rom_word(pend_addr[0]);
      end else begin
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
      end
    end
  end

  // Monitor: every ID transfer must match the next expected PC and its word.
  initial begin : monitor
    logic [ADDR_W-1:0] exp_pc;
    forever begin
      @(negedge clk);
      if (!rst && id_valid_o && id_ready_i) begin
        deliv_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_delivery: got pc 0x%08h, expected no transfer", id_pc_o);
        end else begin
          exp_pc = sb.pop_front();
          check("id_pc", id_pc_o, exp_pc);
          check("id_inst", id_inst_o, rom_word(exp_pc));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // Hold reset 3 cycles and check the reset state; returns in cycle c0
  // (rst just released, DUT still IDLE).
  task automatic reset_dut(input int latency);
    rst             = 1'b1;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    id_ready_i      = 1'b0;
    rom_gnt_i       = 1'b1;
    lat             = latency;
    sb.delete();
    repeat (3) tick();
    @(negedge clk);
    check("rst_ce",    rom_ce_o,   0);
    check("rst_req",   rom_req_o,  0);
    check("rst_addr",  rom_addr_o, 32'h0);
    check("rst_valid", id_valid_o, 0);
    check("rst_pc",    id_pc_o,    32'h0);
    check("rst_inst",  id_inst_o,  32'h0);
    tick();
    rst = 1'b0;
  endtask

  // Let the stalled queue fill, then release ID for exactly 4 transfers.
  task automatic drain4(input logic [ADDR_W-1:0] base, input string tag);
    int d0;
    repeat (20) tick();
    @(negedge clk);
    check({tag, "_full_valid"}, id_valid_o, 1);
    check({tag, "_full_noreq"}, rom_req_o, 0);
    for (int i = 0; i < 4; i++) sb.push_back(base + 32'(4 * i));
    d0 = deliv_cnt;
    tick();
    id_ready_i = 1'b1;
    repeat (4) tick();
    id_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_delivered"}, 32'(deliv_cnt - d0), 4);
    check({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin : stimulus
    int d0;
    int g0;
    rst             = 1'b1;
    rom_gnt_i       = 1'b0;
    id_ready_i      = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;

    // 1: streaming at one instruction per cycle from reset
    reset_dut(1);
    id_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
    d0 = deliv_cnt;
    @(negedge clk);
    check("t1_ce_idle", rom_ce_o, 0);
    tick();                                     // c1
    @(negedge clk);
    check("t1_ce_run",   rom_ce_o,   1);
    check("t1_req",      rom_req_o,  1);
    check("t1_addr",     rom_addr_o, 32'h0);
    check("t1_valid_c1", id_valid_o, 0);
    tick();                                     // c2
    @(negedge clk);
    check("t1_valid_c2", id_valid_o, 0);
    tick();                                     // c3
    @(negedge clk);
    check("t1_valid_c3", id_valid_o, 1);
    repeat (8) tick();                          // c11
    id_ready_i = 1'b0;
    @(negedge clk);
    check("t1_delivered", 32'(deliv_cnt - d0), 8);
    check("t1_sb_empty",  32'(sb.size()), 0);

    // 2: stall fills the queue with DEPTH grants, then releases in order
    reset_dut(1);
    g0 = gnt_cnt;
    repeat (20) tick();
    @(negedge clk);
    check("t2_grants",      32'(gnt_cnt - g0), DEPTH);
    check("t2_req_dropped", rom_req_o,  0);
    check("t2_head_valid",  id_valid_o, 1);
    check("t2_head_pc",     id_pc_o,    32'h0);
    check("t2_head_inst",   id_inst_o,  rom_word(32'h0));
    drain4(32'h0, "t2");

    // 3: redirect to 0x100 with 2 queued and 2 live at 3-cycle latency
    reset_dut(3);
    repeat (6) tick();                          // c6
    branch_target_i = 32'h100;
    branch_flag_i   = 1'b1;
    @(negedge clk);
    check("t3_valid_before", id_valid_o, 1);
    check("t3_req_branch",   rom_req_o,  0);
    tick();                                     // c7
    branch_flag_i = 1'b0;
    @(negedge clk);
    check("t3_cleared",  id_valid_o, 0);
    check("t3_req",      rom_req_o,  1);
    check("t3_addr",     rom_addr_o, 32'h100);
    drain4(32'h100, "t3");

    // 4: back-to-back redirects, only the second target is fetched
    reset_dut(3);
    repeat (3) tick();                          // c3
    branch_target_i = 32'h200;
    branch_flag_i   = 1'b1;
    @(negedge clk);
    check("t4_req_br1", rom_req_o, 0);
    tick();                                     // c4
    branch_target_i = 32'h300;
    @(negedge clk);
    check("t4_req_br2", rom_req_o, 0);
    tick();                                     // c5
    branch_flag_i = 1'b0;
    @(negedge clk);
    check("t4_req",  rom_req_o,  1);
    check("t4_addr", rom_addr_o, 32'h300);
    drain4(32'h300, "t4");

    // 5: reset pulse with 2 responses pending; they land after reset
    reset_dut(3);
    tick();                                     // c1
    tick();                                     // c2
    tick();                                     // c3
    rom_gnt_i = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("t5_ce_in_rst",  rom_ce_o,  0);
    check("t5_req_in_rst", rom_req_o, 0);
    tick();                                     // c4: IDLE, orphan response
    rst       = 1'b0;
    rom_gnt_i = 1'b1;
    sb.delete();
    @(negedge clk);
    check("t5_ce_idle",   rom_ce_o,   0);
    check("t5_req_idle",  rom_req_o,  0);
    check("t5_addr_idle", rom_addr_o, 32'h0);
    check("t5_valid",     id_valid_o, 0);
    tick();                                     // c5: RUN, orphan response
    @(negedge clk);
    check("t5_ce_run", rom_ce_o,   1);
    check("t5_req",    rom_req_o,  1);
    check("t5_addr",   rom_addr_o, 32'h0);
    drain4(32'h0, "t5");

    // 6: redirect to the top word wraps to 0; unaligned target is aligned
    reset_dut(1);
    repeat (3) tick();                          // c3
    branch_target_i = 32'hFFFF_FFFC;
    branch_flag_i   = 1'b1;
    tick();                                     // c4
    branch_flag_i = 1'b0;
    @(negedge clk);
    check("t6_req",  rom_req_o,  1);
    check("t6_addr", rom_addr_o, 32'hFFFF_FFFC);
    drain4(32'hFFFF_FFFC, "t6_wrap");
    branch_target_i = 32'h103;
    branch_flag_i   = 1'b1;
    tick();
    branch_flag_i = 1'b0;
    @(negedge clk);
    check("t6_align_req",  rom_req_o,  1);
    check("t6_align_addr", rom_addr_o, 32'h100);
    drain4(32'h100, "t6_align");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
